// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-port arbiter and access sequencer in front of a single data memory
//   (byte address, 32-bit words, synchronous write, combinational read).
//   Accesses are serialised through IDLE -> ACCESS -> RESP. When both ports
//   request at once, the port granted less recently wins.
//   Misaligned addresses (addr[1:0] != 0) suppress the memory write and
//   complete with err = 1 and rd = 0.
//
//   Handshake: a requester raises pX_req with we/addr/wd stable and holds
//   them until the one-cycle pX_ack pulse. pX_rd and pX_err are valid only
//   while pX_ack is high. If req is still high in the cycle after ack, that
//   is a new request, and its fields must already hold the new values.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   p0_req/we/addr/wd               port 0 request (core load/store path)
//   p0_ack/err/rd                   port 0 completion, error flag, read data
//   p1_*                            same set of signals for port 1 (debug/loader)
//   mem_we/mem_addr/mem_wd          outputs to the memory
//   mem_rd                          combinational read data from the memory
//   dbg_state                       current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
module dmem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wd,
   output logic              p0_ack,
   output logic              p0_err,
   output logic [DATA_W-1:0] p0_rd,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wd,
   output logic              p1_ack,
   output logic              p1_err,
   output logic [DATA_W-1:0] p1_rd,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic [DATA_W-1:0] mem_rd,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_q;
   logic                last_gnt_q;
   logic                gnt_id_q;
   logic                cap_we_q;
   logic [ADDR_W-1:0]   cap_addr_q;
   logic [DATA_W-1:0]   cap_wd_q;
   logic [DATA_W-1:0]   rd_q;
   logic                err_q;
   logic                mem_we_q;
   logic                p0_ack_q;
   logic                p1_ack_q;

   // Grant selection for the IDLE state
   logic                gnt_d;
   logic                sel_we_d;
   logic [ADDR_W-1:0]   sel_addr_d;
   logic [DATA_W-1:0]   sel_wd_d;
   logic                cap_aligned;

   always_comb begin
      gnt_d = 1'b0;
      if (p0_req && p1_req) begin
         // Tie: grant the port that did not win last time
         gnt_d = ~last_gnt_q;
      end else if (p1_req) begin
         gnt_d = 1'b1;
      end
      sel_we_d   = gnt_d ? p1_we   : p0_we;
      sel_addr_d = gnt_d ? p1_addr : p0_addr;
      sel_wd_d   = gnt_d ? p1_wd   : p0_wd;
   end

   assign cap_aligned = (cap_addr_q[1:0] == 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         gnt_id_q   <= 1'b0;
         cap_we_q   <= 1'b0;
         cap_addr_q <= '0;
         cap_wd_q   <= '0;
         rd_q       <= '0;
         err_q      <= 1'b0;
         mem_we_q   <= 1'b0;
         p0_ack_q   <= 1'b0;
         p1_ack_q   <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         p0_ack_q <= 1'b0;
         p1_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (p0_req || p1_req) begin
                  gnt_id_q   <= gnt_d;
                  last_gnt_q <= gnt_d;
                  cap_we_q   <= sel_we_d;
                  cap_addr_q <= sel_addr_d;
                  cap_wd_q   <= sel_wd_d;
                  // Write strobe for the ACCESS cycle, already qualified by
                  // alignment so a misaligned write never reaches memory
                  mem_we_q   <= sel_we_d && (sel_addr_d[1:0] == 2'b00);
                  state_q    <= ACCESS;
               end
            end
            ACCESS: begin
               // Memory read is combinational, so for a write this is the
               // pre-write word
               rd_q     <= cap_aligned ? mem_rd : '0;
               err_q    <= ~cap_aligned;
               p0_ack_q <= ~gnt_id_q;
               p1_ack_q <= gnt_id_q;
               state_q  <= RESP;
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = cap_addr_q;
   assign mem_wd    = cap_wd_q;
   assign p0_ack    = p0_ack_q;
   assign p1_ack    = p1_ack_q;
   assign p0_err    = p0_ack_q & err_q;
   assign p1_err    = p1_ack_q & err_q;
   assign p0_rd     = rd_q;
   assign p1_rd     = rd_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [9:0]  p0_addr, p1_addr;
   logic [31:0] p0_wd, p1_wd;
   logic        p0_ack, p0_err, p1_ack, p1_err;
   logic [31:0] p0_rd, p1_rd;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;
   logic [1:0]  dbg_state;

   int checks = 0;
   int failures = 0;

   // Memory model: combinational read, write on the rising edge
   logic [31:0] mem [0:255];
   assign mem_rd = mem[mem_addr[9:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wd;

   dmem_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rd(p0_rd),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rd(p1_rd),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
      .dbg_state(dbg_state)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      p0_req = 1'b0; p1_req = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic port, input logic req, input logic we,
                        input logic [9:0] addr, input logic [31:0] wd);
      if (port) begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wd = wd;
      end else begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wd = wd;
      end
   endtask

   // Vector table
   typedef struct {
      logic        port;
      logic        we;
      logic [9:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        exp_mem_we;
   } vec_t;

   vec_t vecs [10];

   task automatic do_access(input vec_t v);
      int ack_cyc;
      logic acc_we, own_ack, oth_ack, err;
      logic [31:0] rd;
      ack_cyc = -1; acc_we = 1'b0; own_ack = 1'b0; oth_ack = 1'b0;
      err = 1'b0; rd = '0;
      @(posedge clk); #1;
      drive(v.port, 1'b1, v.we, v.addr, v.wd);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 1) acc_we = mem_we;
         if (p0_ack || p1_ack) begin
            ack_cyc = c;
            own_ack = v.port ? p1_ack : p0_ack;
            oth_ack = v.port ? p0_ack : p1_ack;
            rd      = v.port ? p1_rd  : p0_rd;
            err     = v.port ? p1_err : p0_err;
            break;
         end
      end
      chk("ack_latency", ack_cyc, 32'd2);
      chk("own_ack", {31'd0, own_ack}, 32'd1);
      chk("other_ack", {31'd0, oth_ack}, 32'd0);
      chk("access_mem_we", {31'd0, acc_we}, {31'd0, v.exp_mem_we});
      chk("ack_rd", rd, v.exp_rd);
      chk("ack_err", {31'd0, err}, {31'd0, v.exp_err});
      @(posedge clk); #1;
      drive(v.port, 1'b0, 1'b0, 10'd0, 32'd0);
   endtask

   // Scoreboard for multi-ack sequences: entries are {port, ack cycle}
   logic [4:0] exp_q [$];

   initial begin
      int c;
      logic [4:0] e;
      logic [31:0] wvals [4];
      logic [31:0] prior [4];
      int nxt;

      vecs[0] = '{1'b0, 1'b1, 10'h000, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b1};
      vecs[1] = '{1'b0, 1'b0, 10'h000, 32'h00000000, 32'hDEADBEEF, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 10'h004, 32'hCAFEBABE, 32'h00000000, 1'b0, 1'b1};
      vecs[3] = '{1'b1, 1'b0, 10'h004, 32'h00000000, 32'hCAFEBABE, 1'b0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 10'h006, 32'h11111111, 32'h00000000, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 10'h004, 32'h00000000, 32'hCAFEBABE, 1'b0, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 10'h006, 32'h00000000, 32'h00000000, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b1, 10'h004, 32'h55AA55AA, 32'hCAFEBABE, 1'b0, 1'b1};
      vecs[8] = '{1'b1, 1'b1, 10'h3FC, 32'h0BADF00D, 32'h00000000, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 1'b0, 10'h3FC, 32'h00000000, 32'h0BADF00D, 1'b0, 1'b0};

      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      p0_we = 0; p0_addr = 0; p0_wd = 0; p1_we = 0; p1_addr = 0; p1_wd = 0;
      p0_req = 0; p1_req = 0;
      rst_n = 1'b0;
      #12;
      chk("reset_outputs",
          {25'd0, mem_we, p0_ack, p1_ack, p0_err, p1_err, dbg_state}, 32'd0);
      chk("reset_mem_addr", {22'd0, mem_addr}, 32'd0);
      chk("reset_mem_wd", mem_wd, 32'd0);
      chk("reset_rd", p0_rd | p1_rd, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table-driven single accesses
      for (int i = 0; i < 10; i++) do_access(vecs[i]);
      chk("word1_after_misaligned", mem[1], 32'h55AA55AA);

      // Both ports requesting continuously from reset: strict alternation
      do_reset();
      chk("idle_after_reset", {30'd0, dbg_state}, 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 10'h000, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 10'h004, 32'd0);
      exp_q.push_back({1'b0, 4'd2});
      exp_q.push_back({1'b1, 4'd5});
      exp_q.push_back({1'b0, 4'd8});
      exp_q.push_back({1'b1, 4'd11});
      for (c = 0; c < 12; c++) begin
         @(negedge clk);
         if (p0_ack && p1_ack) chk("both_acks_high", 32'd1, 32'd0);
         if (p0_ack || p1_ack) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_ack", {27'd0, p1_ack, c[3:0]}, 32'h1F);
            end else begin
               e = exp_q.pop_front();
               chk("rr_ack_port_cycle", {27'd0, p1_ack, c[3:0]}, {27'd0, e});
               chk("rr_ack_rd", p1_ack ? p1_rd : p0_rd,
                   e[4] ? 32'h55AA55AA : 32'hDEADBEEF);
            end
         end
      end
      chk("rr_all_acks_seen", exp_q.size(), 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      p0_req = 1'b0; p1_req = 1'b0;
      repeat (3) @(posedge clk);

      // Reset during ACCESS of a write
      #1;
      drive(1'b0, 1'b1, 1'b1, 10'h008, 32'h12345678);
      @(negedge clk);
      @(negedge clk);
      chk("mid_access_we_before", {31'd0, mem_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_access_we_drop", {31'd0, mem_we}, 32'd0);
      chk("mid_access_state", {30'd0, dbg_state}, 32'd0);
      p0_req = 1'b0;
      @(negedge clk);
      chk("mid_access_no_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
      chk("mid_access_word2", mem[2], 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 10'h000, 32'd0);
      drive(1'b1, 1'b1, 1'b0, 10'h004, 32'd0);
      c = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (p0_ack || p1_ack) begin
            c = k;
            chk("post_reset_tie_winner", {30'd0, p0_ack, p1_ack}, 32'd2);
            break;
         end
      end
      chk("post_reset_tie_latency", c, 32'd2);
      @(posedge clk); #1;
      p0_req = 1'b0; p1_req = 1'b0;
      repeat (3) @(posedge clk);

      // Port 1 alone, four back-to-back writes
      wvals = '{32'h10101010, 32'h20202020, 32'h30303030, 32'h40404040};
      prior = '{32'hDEADBEEF, 32'h55AA55AA, 32'h00000000, 32'h00000000};
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 4'(2 + 3 * k)});
      #1;
      drive(1'b1, 1'b1, 1'b1, 10'h000, wvals[0]);
      nxt = 1;
      for (c = 0; c < 16; c++) begin
         @(negedge clk);
         if (p0_ack) chk("b2b_p0_ack", 32'd1, 32'd0);
         if (p1_ack) begin
            if (exp_q.size() == 0) begin
               chk("b2b_unexpected_ack", c, 32'hFF);
            end else begin
               e = exp_q.pop_front();
               chk("b2b_ack_cycle", {27'd0, p1_ack, c[3:0]}, {27'd0, e});
               chk("b2b_ack_rd", p1_rd, prior[nxt-1]);
            end
            // Next request's fields are set before the following IDLE cycle
            if (nxt < 4) begin
               p1_addr = 10'(4 * nxt);
               p1_wd = wvals[nxt];
               nxt++;
            end else begin
               p1_req = 1'b0;
            end
         end
      end
      chk("b2b_all_acks_seen", exp_q.size(), 32'd0);
      exp_q.delete();
      for (int k = 0; k < 4; k++) chk("b2b_word", mem[k], wvals[k]);

      // Reset during RESP: ack falls at once, committed write remains
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b1, 10'h00C, 32'hA5A5A5A5);
      c = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (p1_ack) begin c = k; break; end
      end
      chk("mid_resp_ack_seen", c, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("mid_resp_ack_drop", {31'd0, p1_ack}, 32'd0);
      chk("mid_resp_word3", mem[3], 32'hA5A5A5A5);
      p1_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
